// File: rtl/uart_echo_queue_pkg.sv
// uart_echo_queue_pkg: shared FSM state encoding and counter width for the echo queue.
package uart_echo_queue_pkg;
  localparam int DROP_CNT_W = 8;
  typedef enum logic [1:0] {Q_IDLE = 2'd0, Q_SEND = 2'd1, Q_GAP = 2'd2} q_state_t;
endpackage

// File: rtl/uart_echo_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read; full/empty decided on level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign dout = mem[rd_ptr];
  assign do_pop = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_echo_queue.sv
// uart_echo_queue: buffers good rx bytes in a FIFO and feeds them to the tx start/done handshake.
module uart_echo_queue
  import uart_echo_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx_clk,
  input  logic                  uart_rx_done,
  input  logic                  uart_rx_err,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_tx_clk,
  input  logic                  uart_tx_done,
  output logic                  uart_tx_start,
  output logic [7:0]            uart_tx_data,
  output logic [AW:0]           level,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  q_state_t state, state_n;
  logic rx_stb, push, pop, full, empty, lost, drop;
  logic [7:0] head;
  assign rx_stb = uart_rx_clk & uart_rx_done;
  assign push = rx_stb & ~uart_rx_err;
  assign pop = (state == Q_IDLE) & ~empty;
  assign lost = push & full & ~pop;
  assign drop = (rx_stb & uart_rx_err) | lost;
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (uart_rx_data),
    .pop  (pop),
    .dout (head),
    .level(level),
    .full (full),
    .empty(empty)
  );
  // GAP waits for a tick with done low so a lingering done cannot end the next frame
  always_comb begin
    state_n = state;
    state_n = pop ? Q_SEND
            : (state == Q_SEND && uart_tx_clk && uart_tx_done) ? Q_GAP
            : (state == Q_GAP && uart_tx_clk && !uart_tx_done) ? Q_IDLE
            : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= Q_IDLE;
      uart_tx_start <= 1'b0;
      uart_tx_data <= 8'h00;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      uart_tx_start <= state_n == Q_SEND;
      uart_tx_data <= pop ? head : uart_tx_data;
      overflow <= overflow | lost;
      drop_cnt <= drop_cnt + DROP_CNT_W'(drop & ~&drop_cnt);
    end
endmodule
